// File: rtl/ss_input_ctrl.sv
// ss_input_ctrl: input conditioning for the ScooterShooter core.
// Decodes PS/2 key events into held-key state and merges them with both joystick words.
// Drives the core's active-low control inputs, shapes coin requests into timed pulses
// with a queue of pending requests, and toggles a pause request on each pause press.
module ss_input_ctrl #(
  parameter int CLK_HZ   = 49152000,
  parameter int PULSE_MS = 50,
  parameter int GAP_MS   = 50,
  parameter int PEND_MAX = 3
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [1:0]  coin_n,
  output logic [1:0]  start_n,
  output logic        service_n,
  output logic [3:0]  p1_joy_n,
  output logic [3:0]  p2_joy_n,
  output logic        p1_fire_n,
  output logic        p2_fire_n,
  output logic        pause_req
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX   = (PULSE_MS > GAP_MS) ? PULSE_MS : GAP_MS;
  localparam int MS_W     = $clog2(MS_MAX + 1);
  localparam int PEND_W   = $clog2(PEND_MAX + 1);

  // Bit positions inside the held-key register
  localparam int K_START1 = 0,  K_START2 = 1,  K_COIN1 = 2,  K_COIN2 = 3;
  localparam int K_SERV   = 4,  K_PAUSE  = 5;
  localparam int K_P1U    = 6,  K_P1D    = 7,  K_P1L   = 8,  K_P1R   = 9,  K_P1F = 10;
  localparam int K_P2U    = 11, K_P2D    = 12, K_P2L   = 13, K_P2R   = 14, K_P2F = 15;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PULSE = 2'd1, ST_GAP = 2'd2} coin_st_t;

  logic              r_ps2_tog;
  logic [15:0]       r_keys;
  logic [PS_W-1:0]   r_ps_cnt;
  coin_st_t          r_state  [2];
  logic [MS_W-1:0]   r_ms_cnt [2];
  logic [PEND_W-1:0] r_pend   [2];
  logic [1:0]        r_coin_prev;
  logic [1:0]        r_coin_n;
  logic              r_pause_prev;
  logic              r_pause_req;

  logic [3:0] w_m_p1;
  logic [3:0] w_m_p2;
  logic [1:0] w_m_start;
  logic       w_m_fire1;
  logic       w_m_fire2;
  logic [1:0] w_coin_req;
  logic [1:0] w_coin_edge;
  logic       w_pause;
  logic       w_ms_tick;
  logic       w_unused;

  // Merged held state, packed as {D,U,R,L} for the joystick groups
  assign w_m_p1      = {r_keys[K_P1D] | joystick_0[2], r_keys[K_P1U] | joystick_0[3],
                        r_keys[K_P1R] | joystick_0[0], r_keys[K_P1L] | joystick_0[1]};
  assign w_m_p2      = {r_keys[K_P2D] | joystick_1[2], r_keys[K_P2U] | joystick_1[3],
                        r_keys[K_P2R] | joystick_1[0], r_keys[K_P2L] | joystick_1[1]};
  assign w_m_start   = {r_keys[K_START2] | joystick_1[5], r_keys[K_START1] | joystick_0[5]};
  assign w_m_fire1   = r_keys[K_P1F] | joystick_0[4];
  assign w_m_fire2   = r_keys[K_P2F] | joystick_1[4];
  assign w_coin_req  = {r_keys[K_COIN2], r_keys[K_COIN1] | joystick_0[6] | joystick_1[6]};
  assign w_coin_edge = w_coin_req & ~r_coin_prev;
  assign w_pause     = r_keys[K_PAUSE] | joystick_0[7] | joystick_1[7];
  assign w_ms_tick   = (r_ps_cnt == PS_W'(TICK_DIV - 1));
  assign w_unused    = &{1'b0, ps2_key[8], joystick_0[15:8], joystick_1[15:8]};

  assign coin_n    = r_coin_n;
  assign pause_req = r_pause_req;

  // Detect a new PS/2 event by its toggle bit and latch pressed/released for known codes
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_ps2_tog <= 1'b0;
      r_keys    <= 16'h0000;
    end else begin
      r_ps2_tog <= ps2_key[10];
      if (ps2_key[10] != r_ps2_tog) begin
        case (ps2_key[7:0])
          8'h16:   r_keys[K_START1] <= ps2_key[9];
          8'h1E:   r_keys[K_START2] <= ps2_key[9];
          8'h2E:   r_keys[K_COIN1]  <= ps2_key[9];
          8'h36:   r_keys[K_COIN2]  <= ps2_key[9];
          8'h46:   r_keys[K_SERV]   <= ps2_key[9];
          8'h4D:   r_keys[K_PAUSE]  <= ps2_key[9];
          8'h75:   r_keys[K_P1U]    <= ps2_key[9];
          8'h72:   r_keys[K_P1D]    <= ps2_key[9];
          8'h6B:   r_keys[K_P1L]    <= ps2_key[9];
          8'h74:   r_keys[K_P1R]    <= ps2_key[9];
          8'h14:   r_keys[K_P1F]    <= ps2_key[9];
          8'h1D:   r_keys[K_P2U]    <= ps2_key[9];
          8'h1B:   r_keys[K_P2D]    <= ps2_key[9];
          8'h1C:   r_keys[K_P2L]    <= ps2_key[9];
          8'h23:   r_keys[K_P2R]    <= ps2_key[9];
          8'h2A:   r_keys[K_P2F]    <= ps2_key[9];
          default: r_keys           <= r_keys;
        endcase
      end
    end
  end

  // Register the inverted merged state onto the active-low direct outputs
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      p1_joy_n  <= 4'b1111;
      p2_joy_n  <= 4'b1111;
      start_n   <= 2'b11;
      service_n <= 1'b1;
      p1_fire_n <= 1'b1;
      p2_fire_n <= 1'b1;
    end else begin
      p1_joy_n  <= ~w_m_p1;
      p2_joy_n  <= ~w_m_p2;
      start_n   <= ~w_m_start;
      service_n <= ~r_keys[K_SERV];
      p1_fire_n <= ~w_m_fire1;
      p2_fire_n <= ~w_m_fire2;
    end
  end

  // Free-running millisecond prescaler
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_ps_cnt <= {PS_W{1'b0}};
    end else if (w_ms_tick) begin
      r_ps_cnt <= {PS_W{1'b0}};
    end else begin
      r_ps_cnt <= r_ps_cnt + PS_W'(1);
    end
  end

  // Per-slot coin shaper. The first tick after entering PULSE or GAP only aligns to the
  // prescaler, so each phase lasts at least PULSE_MS / GAP_MS whole milliseconds.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        r_state[s]  <= ST_IDLE;
        r_ms_cnt[s] <= {MS_W{1'b0}};
        r_pend[s]   <= {PEND_W{1'b0}};
      end
      r_coin_prev <= 2'b00;
      r_coin_n    <= 2'b11;
    end else begin
      r_coin_prev <= w_coin_req;
      for (int s = 0; s < 2; s++) begin
        case (r_state[s])
          ST_IDLE: begin
            if (w_coin_edge[s] || (r_pend[s] != {PEND_W{1'b0}})) begin
              r_state[s]  <= ST_PULSE;
              r_ms_cnt[s] <= {MS_W{1'b0}};
              r_coin_n[s] <= 1'b0;
              // An edge arriving while requests wait joins the queue tail, net count unchanged
              if (!w_coin_edge[s]) begin
                r_pend[s] <= r_pend[s] - PEND_W'(1);
              end
            end
          end
          ST_PULSE: begin
            if (w_coin_edge[s] && (r_pend[s] != PEND_W'(PEND_MAX))) begin
              r_pend[s] <= r_pend[s] + PEND_W'(1);
            end
            if (w_ms_tick) begin
              if (r_ms_cnt[s] == MS_W'(PULSE_MS)) begin
                r_state[s]  <= ST_GAP;
                r_ms_cnt[s] <= {MS_W{1'b0}};
                r_coin_n[s] <= 1'b1;
              end else begin
                r_ms_cnt[s] <= r_ms_cnt[s] + MS_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (w_coin_edge[s] && (r_pend[s] != PEND_W'(PEND_MAX))) begin
              r_pend[s] <= r_pend[s] + PEND_W'(1);
            end
            if (w_ms_tick) begin
              if (r_ms_cnt[s] == MS_W'(GAP_MS)) begin
                r_state[s]  <= ST_IDLE;
                r_ms_cnt[s] <= {MS_W{1'b0}};
              end else begin
                r_ms_cnt[s] <= r_ms_cnt[s] + MS_W'(1);
              end
            end
          end
          default: begin
            r_state[s]  <= ST_IDLE;
            r_coin_n[s] <= 1'b1;
          end
        endcase
      end
    end
  end

  // Toggle the pause request on each rising edge of the merged pause input
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_pause_prev <= 1'b0;
      r_pause_req  <= 1'b0;
    end else begin
      r_pause_prev <= w_pause;
      if (w_pause && !r_pause_prev) begin
        r_pause_req <= ~r_pause_req;
      end else begin
        r_pause_req <= r_pause_req;
      end
    end
  end

endmodule

// File: tb/tb_ss_input_ctrl.sv
// Scoreboard bench for ss_input_ctrl with a 4-clock millisecond (CLK_HZ=4000).
// Expected output changes are queued per channel; a monitor pops them as outputs move.
module tb_ss_input_ctrl;

  localparam int BIG = 1000000;
  // Channels: 0 p1_joy_n 1 p2_joy_n 2 start_n 3 service_n 4 p1_fire_n 5 p2_fire_n
  //           6 coin_n[0] 7 coin_n[1] 8 pause_req

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ps2_key = 11'h000;
  logic [15:0] j0 = 16'h0000;
  logic [15:0] j1 = 16'h0000;
  logic [1:0]  coin_n, start_n;
  logic        service_n, p1_fire_n, p2_fire_n, pause_req;
  logic [3:0]  p1_joy_n, p2_joy_n;

  typedef struct { int ch; logic [3:0] val; int lo; int hi; } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise [2];
  int last_fall [2];

  ss_input_ctrl #(.CLK_HZ(4000), .PULSE_MS(3), .GAP_MS(2), .PEND_MAX(3)) dut (
    .clk_49m(clk), .reset(rst_n), .ps2_key(ps2_key), .joystick_0(j0), .joystick_1(j1),
    .coin_n(coin_n), .start_n(start_n), .service_n(service_n),
    .p1_joy_n(p1_joy_n), .p2_joy_n(p2_joy_n), .p1_fire_n(p1_fire_n),
    .p2_fire_n(p2_fire_n), .pause_req(pause_req)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input int ch, input logic [3:0] val, input int lo, input int hi);
    exp_t e;
    e.ch = ch; e.val = val; e.lo = lo; e.hi = hi;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int ch, input logic [3:0] val, input int dur);
    int idx;
    exp_t e;
    idx = -1;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].ch == ch) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      failures++;
      $display("FAIL sb_ch%0d unexpected: got=%h dur=%0d required=no change", ch, val, dur);
    end else begin
      e = sb_q[idx];
      sb_q.delete(idx);
      if (val !== e.val || dur < e.lo || dur > e.hi) begin
        failures++;
        $display("FAIL sb_ch%0d: got=%h dur=%0d required=%h dur=%0d..%0d",
                 ch, val, dur, e.val, e.lo, e.hi);
      end
    end
  endtask

  // Monitor: any output movement is an event popped from the scoreboard
  initial begin
    logic [3:0] pv_p1, pv_p2;
    logic [1:0] pv_start, pv_coin;
    logic       pv_serv, pv_f1, pv_f2, pv_pause;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (p1_joy_n !== pv_p1) sb_check(0, p1_joy_n, 0);
        if (p2_joy_n !== pv_p2) sb_check(1, p2_joy_n, 0);
        if (start_n !== pv_start) sb_check(2, {2'b00, start_n}, 0);
        if (service_n !== pv_serv) sb_check(3, {3'b000, service_n}, 0);
        if (p1_fire_n !== pv_f1) sb_check(4, {3'b000, p1_fire_n}, 0);
        if (p2_fire_n !== pv_f2) sb_check(5, {3'b000, p2_fire_n}, 0);
        for (int s = 0; s < 2; s++) begin
          if (coin_n[s] !== pv_coin[s]) begin
            if (coin_n[s] == 1'b0) begin
              sb_check(6 + s, 4'h0, cyc - last_rise[s]);
              last_fall[s] = cyc;
            end else begin
              sb_check(6 + s, 4'h1, cyc - last_fall[s]);
              last_rise[s] = cyc;
            end
          end
        end
        if (pause_req !== pv_pause) sb_check(8, {3'b000, pause_req}, 0);
      end else begin
        last_rise[0] = cyc;
        last_rise[1] = cyc;
      end
      pv_p1 = p1_joy_n; pv_p2 = p2_joy_n; pv_start = start_n; pv_serv = service_n;
      pv_f1 = p1_fire_n; pv_f2 = p2_fire_n; pv_coin = coin_n; pv_pause = pause_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got=%h required=%h", nm, act, exp_v);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain: outstanding=%0d required=0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic key(input logic pr, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, 1'b0, code};
    tick(1);
  endtask

  // One key event with the single output change it must cause
  task automatic kstep(input logic pr, input logic [7:0] code, input int ch, input logic [3:0] v);
    push(ch, v, 0, 0);
    key(pr, code);
    drain("key", 10);
  endtask

  initial begin
    tick(3);
    chk("rst_joy", {8'h00, p1_joy_n, p2_joy_n}, 16'h00FF);
    chk("rst_ctl", {11'h000, start_n, service_n, p1_fire_n, p2_fire_n}, 16'h001F);
    chk("rst_coin", {14'h0000, coin_n}, 16'h0003);
    chk("rst_pause", {15'h0000, pause_req}, 16'h0000);
    rst_n = 1'b1;
    tick(4);

    // Test 1: key decode, release, repeated event without toggle, merge with joystick
    kstep(1'b1, 8'h75, 0, 4'b1011);
    kstep(1'b0, 8'h75, 0, 4'b1111);
    ps2_key = {ps2_key[10], 1'b1, 1'b0, 8'h75};
    tick(6);
    kstep(1'b1, 8'h72, 0, 4'b0111);
    kstep(1'b0, 8'h72, 0, 4'b1111);
    kstep(1'b1, 8'h1C, 1, 4'b1110);
    kstep(1'b0, 8'h1C, 1, 4'b1111);
    kstep(1'b1, 8'h16, 2, 4'b0010);
    kstep(1'b0, 8'h16, 2, 4'b0011);
    kstep(1'b1, 8'h46, 3, 4'b0000);
    kstep(1'b0, 8'h46, 3, 4'b0001);
    kstep(1'b1, 8'h14, 4, 4'b0000);
    kstep(1'b0, 8'h14, 4, 4'b0001);
    key(1'b1, 8'h55);
    tick(6);
    push(0, 4'b1101, 0, 0); j0 = 16'h0001; drain("j0_r", 10);
    push(0, 4'b1111, 0, 0); j0 = 16'h0000; drain("j0_r_off", 10);
    push(5, 4'b0000, 0, 0); j1 = 16'h0010; drain("j1_fire", 10);
    push(5, 4'b0001, 0, 0); j1 = 16'h0000; drain("j1_fire_off", 10);
    kstep(1'b1, 8'h75, 0, 4'b1011);
    j0 = 16'h0008; tick(3);
    key(1'b0, 8'h75); tick(3);
    push(0, 4'b1111, 0, 0); j0 = 16'h0000; drain("merge_u", 10);

    // Test 2: held coin request gives exactly one pulse
    push(6, 4'h0, 0, BIG);
    push(6, 4'h1, 12, 16);
    j0 = 16'h0040;
    tick(100);
    j0 = 16'h0000;
    drain("t2", 50);
    tick(30);

    // Test 3: five rapid edges -> one pulse plus three queued
    push(6, 4'h0, 0, BIG);
    push(6, 4'h1, 12, 16);
    for (int i = 0; i < 3; i++) begin
      push(6, 4'h0, 8, 14);
      push(6, 4'h1, 12, 16);
    end
    for (int i = 0; i < 5; i++) begin
      j0 = 16'h0040; tick(1);
      j0 = 16'h0000; tick(1);
    end
    drain("t3", 300);
    tick(40);

    // Test 4: coin1 and coin2 edges on the same clock
    push(6, 4'h0, 0, BIG); push(7, 4'h0, 0, BIG);
    push(6, 4'h1, 12, 16); push(7, 4'h1, 12, 16);
    key(1'b1, 8'h36);
    j0 = 16'h0040;
    tick(5);
    key(1'b0, 8'h36);
    j0 = 16'h0000;
    drain("t4", 100);
    chk("t4_same_fall", 16'(last_fall[0] - last_fall[1]), 16'h0000);
    tick(30);

    // Test 6: pause toggles on key presses, held joystick toggles once
    kstep(1'b1, 8'h4D, 8, 4'h1);
    key(1'b0, 8'h4D); tick(3);
    kstep(1'b1, 8'h4D, 8, 4'h0);
    key(1'b0, 8'h4D); tick(3);
    push(8, 4'h1, 0, 0);
    j1 = 16'h0080;
    tick(50);
    j1 = 16'h0000;
    drain("t6_hold", 10);
    tick(10);

    // Test 5: reset mid-pulse with two requests pending
    push(6, 4'h0, 0, BIG);
    for (int i = 0; i < 3; i++) begin
      j0 = 16'h0040; tick(1);
      j0 = 16'h0000; tick(1);
    end
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_coin_async", {14'h0000, coin_n}, 16'h0003);
    chk("t5_pause_async", {15'h0000, pause_req}, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(100);
    chk("t5_coin_after", {14'h0000, coin_n}, 16'h0003);
    drain("final", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
